string_note_matcher: RTL and testbench

Judges player plucks against the note chart for one string and produces hit/miss events plus a running score. It sits directly upstream of the per-string note renderer, driving its `match_en` / `fret` / `match_time` inputs, and it reads the same note-time and note-fret chart memories through its own read port. One instance is used per string.

---
 rtl/gh_pkg.sv | 25 ++
 rtl/string_note_matcher_score_accum.sv | 42 ++++
 rtl/string_note_matcher.sv | 130 +++++++++++++
 tb/tb_string_note_matcher.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gh_pkg.sv
// Shared types and constants for the per-string note judging logic.
package gh_pkg;

  localparam int unsigned SONG_TIME_W    = 16;
  localparam int unsigned FRET_W         = 5;
  localparam int unsigned SCORE_W        = 16;
  localparam int unsigned STREAK_W       = 8;
  localparam int unsigned DEF_WINDOW     = 8;
  localparam int unsigned DEF_HIT_POINTS = 10;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ARMED = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Multiplier tier from the streak: min(streak >> 3, 3).
  function automatic logic [1:0] streak_tier(input logic [STREAK_W-1:0] streak);
    logic [STREAK_W-1:0] eighths;
    eighths = streak >> 3;
    return (eighths > STREAK_W'(3)) ? 2'd3 : eighths[1:0];
  endfunction

endpackage

// File: rtl/string_note_matcher_score_accum.sv
// Streak counter and saturating score accumulator driven by hit/break events.
module score_accum
  import gh_pkg::*;
#(
  parameter int unsigned HIT_POINTS = DEF_HIT_POINTS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic                break_streak,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak
);

  logic [2:0]  mult;
  logic [31:0] incr;
  logic [31:0] sum;
  logic [SCORE_W-1:0] score_next;

  // Multiplier uses the streak as it stood before this hit.
  always_comb begin
    mult       = 3'd1 + {1'b0, streak_tier(streak)};
    incr       = HIT_POINTS * 32'(mult);
    sum        = 32'(score) + incr;
    score_next = ((sum >> SCORE_W) != 32'd0) ? '1 : sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score  <= '0;
      streak <= '0;
    end else if (hit) begin
      score <= score_next;
      if (streak != '1) begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (break_streak) begin
      streak <= '0;
    end
  end

endmodule

// File: rtl/string_note_matcher.sv
// Judges plucks on one string against its note chart: hit/miss/bad-pluck pulses and score.
module string_note_matcher
  import gh_pkg::*;
#(
  parameter int unsigned WINDOW     = DEF_WINDOW,
  parameter int unsigned HIT_POINTS = DEF_HIT_POINTS,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_NOTES  = 32
) (
  input  logic                   clk65,
  input  logic                   reset_n,
  input  logic [SONG_TIME_W-1:0] song_time,
  input  logic                   pluck,
  input  logic [FRET_W-1:0]      pluck_fret,
  output logic [ADDR_W-1:0]      note_addr,
  input  logic [SONG_TIME_W-1:0] note_time,
  input  logic [FRET_W-1:0]      note_fret,
  output logic                   match_en,
  output logic [FRET_W-1:0]      match_fret,
  output logic [SONG_TIME_W-1:0] match_time,
  output logic                   miss,
  output logic                   bad_pluck,
  output logic [SCORE_W-1:0]     score,
  output logic [STREAK_W-1:0]    streak,
  output logic                   done
);

  localparam logic [16:0]       WIN17     = 17'(WINDOW);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NOTES - 1);

  state_t                 state;
  logic [SONG_TIME_W-1:0] cur_time;
  logic [FRET_W-1:0]      cur_fret;

  logic [16:0] cur17;
  logic [16:0] song17;
  logic [16:0] win_hi;
  logic [16:0] win_lo;
  logic        in_window;
  logic        armed;
  logic        hit_now;
  logic        bad_now;
  logic        expire_now;
  logic        advance;

  // 17-bit compare so cur_time+WINDOW never wraps; lower bound clamps at zero.
  always_comb begin
    cur17      = {1'b0, cur_time};
    song17     = {1'b0, song_time};
    win_hi     = cur17 + WIN17;
    win_lo     = (cur17 >= WIN17) ? (cur17 - WIN17) : '0;
    in_window  = (song17 >= win_lo) && (song17 <= win_hi);
    armed      = (state == ST_ARMED);
    hit_now    = armed && pluck && (pluck_fret == cur_fret) && in_window;
    bad_now    = armed && pluck && !hit_now;
    expire_now = armed && (song17 > win_hi) && !hit_now;
    advance    = hit_now || expire_now;
  end

  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_FETCH;
      note_addr  <= '0;
      cur_time   <= '0;
      cur_fret   <= '0;
      match_en   <= 1'b0;
      match_fret <= '0;
      match_time <= '0;
      miss       <= 1'b0;
      bad_pluck  <= 1'b0;
      done       <= 1'b0;
    end else begin
      match_en  <= 1'b0;
      miss      <= 1'b0;
      bad_pluck <= 1'b0;
      case (state)
        ST_FETCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cur_time <= note_time;
          cur_fret <= note_fret;
          // A zero time past the first slot marks the end of the chart.
          if ((note_time == '0) && (note_addr != '0)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          match_en  <= hit_now;
          bad_pluck <= bad_now;
          miss      <= expire_now;
          if (hit_now) begin
            match_fret <= cur_fret;
            match_time <= cur_time;
          end
          if (advance) begin
            if (note_addr == LAST_ADDR) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              note_addr <= note_addr + ADDR_W'(1);
              state     <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_DONE;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

  score_accum #(
    .HIT_POINTS (HIT_POINTS)
  ) u_score_accum (
    .clk          (clk65),
    .rst_n        (reset_n),
    .hit          (hit_now),
    .break_streak (bad_now || expire_now),
    .score        (score),
    .streak       (streak)
  );

endmodule

// File: tb/tb_string_note_matcher.sv
// Directed bench for string_note_matcher with a one-cycle-latency chart memory model.
module tb_string_note_matcher;

  localparam int unsigned AW    = 11;
  localparam int unsigned NOTES = 2048;

  logic        clk65 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] song_time = '0;
  logic        pluck = 1'b0;
  logic [4:0]  pluck_fret = '0;
  logic [AW-1:0] note_addr;
  logic [15:0] note_time;
  logic [4:0]  note_fret;
  logic        match_en;
  logic [4:0]  match_fret;
  logic [15:0] match_time;
  logic        miss;
  logic        bad_pluck;
  logic [15:0] score;
  logic [7:0]  streak;
  logic        done;

  logic [15:0] chart_time [0:NOTES-1];
  logic [4:0]  chart_fret [0:NOTES-1];

  int tests = 0;
  int fails = 0;

  always #5 clk65 = ~clk65;

  always_ff @(posedge clk65) begin
    note_time <= chart_time[note_addr];
    note_fret <= chart_fret[note_addr];
  end

  string_note_matcher #(
    .WINDOW     (8),
    .HIT_POINTS (10),
    .ADDR_W     (AW),
    .NUM_NOTES  (NOTES)
  ) dut (
    .clk65      (clk65),
    .reset_n    (reset_n),
    .song_time  (song_time),
    .pluck      (pluck),
    .pluck_fret (pluck_fret),
    .note_addr  (note_addr),
    .note_time  (note_time),
    .note_fret  (note_fret),
    .match_en   (match_en),
    .match_fret (match_fret),
    .match_time (match_time),
    .miss       (miss),
    .bad_pluck  (bad_pluck),
    .score      (score),
    .streak     (streak),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk65);
    #1;
  endtask

  task automatic rearm();
    tick();
    tick();
  endtask

  task automatic pluck_at(input logic [4:0] f, input logic [15:0] t);
    song_time  = t;
    pluck_fret = f;
    pluck      = 1'b1;
    tick();
    pluck      = 1'b0;
  endtask

  task automatic clear_chart();
    for (int i = 0; i < int'(NOTES); i++) begin
      chart_time[i] = '0;
      chart_fret[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    pluck     = 1'b0;
    song_time = '0;
    #2;
    reset_n   = 1'b1;
  endtask

  task automatic test_reset();
    clear_chart();
    chart_time[0] = 16'd100; chart_fret[0] = 5'd2;
    chart_time[1] = 16'd200; chart_fret[1] = 5'd4;
    reset_n = 1'b0;
    #1;
    tests++; if (note_addr !== '0) begin fails++; $display("FAIL reset_addr got %0d want 0", note_addr); end
    tests++; if ({match_en, miss, bad_pluck, done} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {match_en, miss, bad_pluck, done}); end
    tests++; if ({score, streak} !== 24'h0) begin fails++; $display("FAIL reset_score got %0d/%0d want 0/0", score, streak); end
    tests++; if ({match_fret, match_time} !== 21'h0) begin fails++; $display("FAIL reset_match got %0d/%0d want 0/0", match_fret, match_time); end
    tick();
    reset_n = 1'b1;
    rearm();
  endtask

  task automatic test_hit();
    pluck_at(5'd2, 16'd95);
    tests++; if (match_en !== 1'b1) begin fails++; $display("FAIL hit_en got %b want 1", match_en); end
    tests++; if (match_time !== 16'd100) begin fails++; $display("FAIL hit_time got %0d want 100", match_time); end
    tests++; if (match_fret !== 5'd2) begin fails++; $display("FAIL hit_fret got %0d want 2", match_fret); end
    tests++; if (score !== 16'd10) begin fails++; $display("FAIL hit_score got %0d want 10", score); end
    tests++; if (streak !== 8'd1) begin fails++; $display("FAIL hit_streak got %0d want 1", streak); end
    tests++; if (note_addr !== 11'd1) begin fails++; $display("FAIL hit_addr got %0d want 1", note_addr); end
    tick();
    tests++; if (match_en !== 1'b0) begin fails++; $display("FAIL hit_pulse_width got %b want 0", match_en); end
    tick();
  endtask

  task automatic test_miss_and_end();
    for (int t = 200; t <= 209; t++) begin
      song_time = 16'(t);
      tick();
      tests++; if (miss !== (t == 209)) begin fails++; $display("FAIL miss_sweep_%0d got %b want %b", t, miss, (t == 209)); end
    end
    tests++; if (streak !== 8'd0) begin fails++; $display("FAIL miss_streak got %0d want 0", streak); end
    tests++; if (note_addr !== 11'd2) begin fails++; $display("FAIL miss_addr got %0d want 2", note_addr); end
    tests++; if (match_time !== 16'd100) begin fails++; $display("FAIL miss_hold_time got %0d want 100", match_time); end
    tick();
    tests++; if ({miss, done} !== 2'b00) begin fails++; $display("FAIL miss_after got %b want 00", {miss, done}); end
    tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL end_marker_done got %b want 1", done); end
    pluck_at(5'd4, 16'd200);
    tests++; if ({match_en, bad_pluck, miss} !== 3'b000) begin fails++; $display("FAIL done_pluck got %b want 000", {match_en, bad_pluck, miss}); end
    tests++; if (score !== 16'd10) begin fails++; $display("FAIL done_score got %0d want 10", score); end
  endtask

  task automatic test_bad_pluck();
    clear_chart();
    chart_time[0] = 16'd5;   chart_fret[0] = 5'd1;
    chart_time[1] = 16'd300; chart_fret[1] = 5'd2;
    chart_time[2] = 16'd400; chart_fret[2] = 5'd3;
    chart_time[3] = 16'd500; chart_fret[3] = 5'd4;
    do_reset();
    rearm();
    pluck_at(5'd1, 16'd0);
    tests++; if (match_en !== 1'b1) begin fails++; $display("FAIL clamp_hit got %b want 1", match_en); end
    rearm();
    pluck_at(5'd3, 16'd300);
    tests++; if ({bad_pluck, match_en} !== 2'b10) begin fails++; $display("FAIL bad_fret got %b want 10", {bad_pluck, match_en}); end
    tests++; if (streak !== 8'd0) begin fails++; $display("FAIL bad_streak got %0d want 0", streak); end
    tests++; if (note_addr !== 11'd1) begin fails++; $display("FAIL bad_addr got %0d want 1", note_addr); end
    pluck_at(5'd2, 16'd291);
    tests++; if ({bad_pluck, match_en} !== 2'b10) begin fails++; $display("FAIL early_pluck got %b want 10", {bad_pluck, match_en}); end
    pluck_at(5'd2, 16'd292);
    tests++; if ({bad_pluck, match_en} !== 2'b01) begin fails++; $display("FAIL low_edge_hit got %b want 01", {bad_pluck, match_en}); end
    tests++; if (score !== 16'd20) begin fails++; $display("FAIL low_edge_score got %0d want 20", score); end
    tests++; if (match_time !== 16'd300) begin fails++; $display("FAIL low_edge_time got %0d want 300", match_time); end
    rearm();
    pluck_at(5'd3, 16'd408);
    tests++; if (match_en !== 1'b1) begin fails++; $display("FAIL high_edge_hit got %b want 1", match_en); end
    tests++; if ({score, streak} !== {16'd30, 8'd2}) begin fails++; $display("FAIL high_edge_score got %0d/%0d want 30/2", score, streak); end
    rearm();
    pluck_at(5'd4, 16'd509);
    tests++; if ({bad_pluck, miss, match_en} !== 3'b110) begin fails++; $display("FAIL pluck_expire got %b want 110", {bad_pluck, miss, match_en}); end
    tests++; if ({note_addr, streak} !== {11'd4, 8'd0}) begin fails++; $display("FAIL pluck_expire_adv got %0d/%0d want 4/0", note_addr, streak); end
    rearm();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL bad_test_done got %b want 1", done); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    clear_chart();
    for (int i = 0; i < 10; i++) begin
      chart_time[i] = 16'(1000 + 20 * i);
      chart_fret[i] = 5'((i % 4) + 1);
    end
    do_reset();
    rearm();
    for (int i = 0; i < 9; i++) begin
      pluck_at(5'((i % 4) + 1), 16'(1000 + 20 * i));
      want = (i < 8) ? 16'(10 * (i + 1)) : 16'd100;
      tests++; if ({match_en, score} !== {1'b1, want}) begin fails++; $display("FAIL streak_hit_%0d got %b/%0d want 1/%0d", i, match_en, score, want); end
      rearm();
    end
    tests++; if ({streak, note_addr} !== {8'd9, 11'd9}) begin fails++; $display("FAIL streak_final got %0d/%0d want 9/9", streak, note_addr); end
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0;
    #1;
    tests++; if ({note_addr, score, streak} !== '0) begin fails++; $display("FAIL mid_reset_state got %0d/%0d/%0d want 0/0/0", note_addr, score, streak); end
    tests++; if ({match_en, miss, bad_pluck, done, match_fret, match_time} !== '0) begin fails++; $display("FAIL mid_reset_outs got %0d/%0d want 0/0", match_fret, match_time); end
    #2;
    reset_n = 1'b1;
    rearm();
    tests++; if (note_addr !== '0) begin fails++; $display("FAIL mid_reset_addr got %0d want 0", note_addr); end
    pluck_at(5'd1, 16'd1000);
    tests++; if ({match_en, match_time, score} !== {1'b1, 16'd1000, 16'd10}) begin fails++; $display("FAIL mid_reset_rearm got %b/%0d/%0d want 1/1000/10", match_en, match_time, score); end
  endtask

  task automatic test_saturation();
    int hits;
    hits = 0;
    for (int i = 0; i < int'(NOTES); i++) begin
      chart_time[i] = 16'(100 + 10 * i);
      chart_fret[i] = 5'(i);
    end
    do_reset();
    rearm();
    for (int i = 0; i < int'(NOTES); i++) begin
      pluck_at(5'(i), 16'(100 + 10 * i));
      if (match_en === 1'b1) hits++;
      if (i == 1649) begin
        tests++; if ({score, streak} !== {16'hFFF0, 8'd255}) begin fails++; $display("FAIL near_sat got %h/%0d want fff0/255", score, streak); end
      end
      if (i == 1650) begin
        tests++; if (score !== 16'hFFFF) begin fails++; $display("FAIL sat_score got %h want ffff", score); end
      end
      if (i < int'(NOTES) - 1) rearm();
    end
    tests++; if (hits !== 2048) begin fails++; $display("FAIL sat_hit_count got %0d want 2048", hits); end
    tests++; if ({done, note_addr, score} !== {1'b1, 11'd2047, 16'hFFFF}) begin fails++; $display("FAIL last_note got %b/%0d/%h want 1/2047/ffff", done, note_addr, score); end
    tick();
    tests++; if ({done, match_en} !== 2'b10) begin fails++; $display("FAIL last_note_hold got %b want 10", {done, match_en}); end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_miss_and_end();
    test_bad_pluck();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
